// File: rtl/npu_host_seq.sv
// npu_host_seq: host-side bus master for the NPU shared data bus.
// Reads a frame (6-word header, then weights/biases/inputs) from local SRAM,
// streams it to the NPU without gaps, waits for npu_ready, then drains the
// NPU outputs with npu_oe onto a valid/ready result stream.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start/base_addr frame request (ignored while busy or in a done/err cycle)
//   busy/done/err   frame status; done/err are 1-cycle pulses
//   mem_rd_en/mem_addr/mem_rdata  SRAM read port (data 1 cycle after strobe)
//   npu_we/npu_oe/npu_data/npu_ready  NPU shared bus
//   res_valid/res_data/res_last/res_ready  result stream
//
// Build option: define NPU_HOST_TIMEOUT_EN to add a watchdog in WAIT that
// raises err after TO_CYCLES cycles without npu_ready.
module npu_host_seq #(
  parameter int AW        = 12,
  parameter int TO_CYCLES = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  output logic          npu_we,
  output logic          npu_oe,
  inout  wire  [31:0]   npu_data,
  input  logic          npu_ready,
  output logic          res_valid,
  output logic [31:0]   res_data,
  output logic          res_last,
  input  logic          res_ready
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_HDR    = 4'd1;
  localparam logic [3:0] S_CALC   = 4'd2;
  localparam logic [3:0] S_WE     = 4'd3;
  localparam logic [3:0] S_CFG    = 4'd4;
  localparam logic [3:0] S_STREAM = 4'd5;
  localparam logic [3:0] S_WAIT   = 4'd6;
  localparam logic [3:0] S_SKIP   = 4'd7;
  localparam logic [3:0] S_DRAIN  = 4'd8;

  logic [3:0]        state_q, state_d;
  logic [11:0]       cnt_q, cnt_d;
  logic [AW-1:0]     base_q, base_d;
  logic [5:0][31:0]  hdr_q, hdr_d;
  logic              hdr_cap_q, hdr_cap_d;
  logic [2:0]        hdr_idx_q, hdr_idx_d;
  logic [2:0][11:0]  prod_q, prod_d;
  logic [11:0]       s_q, s_d;
  logic              res_valid_q, res_valid_d;
  logic [31:0]       res_data_q, res_data_d;
  logic              res_last_q, res_last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              drv_en;
  logic [31:0]       drv_val;

`ifdef NPU_HOST_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TO_CYCLES - 1);
  logic [15:0]       to_cnt_q, to_cnt_d;
`endif

  // Words contributed by one layer pair: Nout*(Nin+1), fields encoded count-1.
  function automatic logic [11:0] pair_words(input logic [4:0] nin_enc,
                                             input logic [4:0] nout_enc);
    logic [11:0] n_out;
    logic [11:0] n_in_p1;
    n_out   = {7'd0, nout_enc} + 12'd1;
    n_in_p1 = {7'd0, nin_enc} + 12'd2;
    return n_out * n_in_p1;
  endfunction

  logic [1:0]  lyr;
  logic [4:0]  n0, n1, n2, n3;
  logic [11:0] n3_words;
  assign lyr      = hdr_q[0][1:0];
  assign n0       = hdr_q[1][4:0];
  assign n1       = hdr_q[2][4:0];
  assign n2       = hdr_q[3][4:0];
  assign n3       = hdr_q[4][4:0];
  assign n3_words = {7'd0, n3} + 12'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    hdr_d       = hdr_q;
    hdr_cap_d   = 1'b0;
    hdr_idx_d   = hdr_idx_q;
    prod_d      = prod_q;
    s_d         = s_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_last_d  = res_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    npu_we      = 1'b0;
    npu_oe      = 1'b0;
    drv_en      = 1'b0;
    drv_val     = '0;
`ifdef NPU_HOST_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif

    // Header words land one cycle after their read strobe.
    if (hdr_cap_q) hdr_d[hdr_idx_q] = mem_rdata;

    case (state_q)
      S_IDLE: begin
        // A start coinciding with the done/err pulse belongs to the old frame.
        if (start && !done_q && !err_q) begin
          base_d  = base_addr;
          cnt_d   = '0;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        mem_rd_en = 1'b1;
        mem_addr  = base_q + AW'(cnt_q);
        hdr_cap_d = 1'b1;
        hdr_idx_d = cnt_q[2:0];
        if (cnt_q == 12'd5) begin
          cnt_d   = '0;
          state_d = S_CALC;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      S_CALC: begin
        if (cnt_q == 12'd0) begin
          if (lyr == 2'd3) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            prod_d[0] = pair_words(n0, (lyr == 2'd0) ? n3 : n1);
            prod_d[1] = (lyr == 2'd0) ? 12'd0 : pair_words(n1, (lyr == 2'd1) ? n3 : n2);
            prod_d[2] = (lyr == 2'd2) ? pair_words(n2, n3) : 12'd0;
            cnt_d     = 12'd1;
          end
        end else begin
          s_d     = prod_q[0] + prod_q[1] + prod_q[2] + {7'd0, n0} + 12'd1;
          cnt_d   = '0;
          state_d = S_WE;
        end
      end
      S_WE: begin
        npu_we  = 1'b1;
        drv_en  = 1'b1;
        state_d = S_CFG;
      end
      S_CFG: begin
        drv_en  = 1'b1;
        drv_val = hdr_q[cnt_q[2:0]];
        if (cnt_q == 12'd5) begin
          // Prefetch the first stream word so STREAM has no bubble.
          mem_rd_en = 1'b1;
          mem_addr  = base_q + AW'(12'd6);
          cnt_d     = '0;
          state_d   = S_STREAM;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      S_STREAM: begin
        drv_en  = 1'b1;
        drv_val = mem_rdata;
        if (cnt_q + 12'd1 < s_q) begin
          mem_rd_en = 1'b1;
          mem_addr  = base_q + AW'(cnt_q + 12'd7);
        end
        if (cnt_q == s_q - 12'd1) begin
          cnt_d   = '0;
          state_d = S_WAIT;
`ifdef NPU_HOST_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      S_WAIT: begin
        if (npu_ready) begin
          state_d = S_SKIP;
        end
`ifdef NPU_HOST_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
`endif
      end
      S_SKIP: begin
        // ready rises one cycle before the NPU starts presenting outputs.
        cnt_d   = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          res_last_d  = 1'b0;
        end
        if (res_valid_q && res_ready && res_last_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q < n3_words && (!res_valid_q || res_ready)) begin
          npu_oe      = 1'b1;
          res_valid_d = 1'b1;
          res_data_d  = npu_data;
          res_last_d  = (cnt_q == n3_words - 12'd1);
          cnt_d       = cnt_q + 12'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hdr_cap_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef NPU_HOST_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hdr_cap_q   <= hdr_cap_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_last_q  <= res_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef NPU_HOST_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  // Frame data registers, always rewritten before use
  always_ff @(posedge clk) begin
    base_q    <= base_d;
    hdr_q     <= hdr_d;
    hdr_idx_q <= hdr_idx_d;
    prod_q    <= prod_d;
    s_q       <= s_d;
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_last  = res_last_q;
  assign npu_data  = drv_en ? drv_val : 'z;

endmodule

// File: tb/tb_npu_host_seq.sv
module tb_npu_host_seq;

  logic        clk, rst, start;
  logic [11:0] base_addr;
  logic        busy, done, err, mem_rd_en, npu_we, npu_oe, npu_ready;
  logic [11:0] mem_addr;
  logic [31:0] mem_rdata, res_data;
  logic        res_valid, res_last, res_ready;
  tri1  [31:0] npu_bus;

  npu_host_seq #(.AW(12), .TO_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .err(err),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .npu_we(npu_we), .npu_oe(npu_oe), .npu_data(npu_bus), .npu_ready(npu_ready),
    .res_valid(res_valid), .res_data(res_data), .res_last(res_last), .res_ready(res_ready)
  );

  // NPU side of the bus: drives its current output word while oe is high.
  logic        npu_drv;
  logic [31:0] out_words [64];
  int          out_idx, out_cnt;
  logic        send_mode;
  assign npu_drv = npu_oe && send_mode;
  assign npu_bus = npu_drv ? out_words[out_idx] : 32'bz;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int compared = 0, mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic flag_fail(input string name, input logic [63:0] act);
    compared++;
    mismatched++;
    $display("FAIL %s unexpected=%0h (cycle %0d)", name, act, cyc);
  endtask

  logic [31:0] mem [4096];
  int          exp_rd[$];
  logic [31:0] exp_bus[$];
  int          exp_run[$];
  logic [32:0] exp_res[$];
  logic [1:0]  exp_end[$];

  int run_len = 0, wait_entry = 0, last_hs = 0, ended = 0;
  bit cur_to = 0, armed = 0, stall_mode = 0, first_seen = 0;
  int rdy_delay = 0, rdy_cnt = 0, stall_left = 0;

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if (w == 32'hFFFF_FFFF) w = 32'h7FFF_FFFF;
    return w;
  endfunction

  // Scoreboard monitor: compares whatever the DUT presents against the queues.
  task automatic mon_step();
    bit driven;
    driven = (npu_bus !== 32'hFFFF_FFFF) && !npu_drv;
    if (mem_rd_en) begin
      if (exp_rd.size() == 0) flag_fail("rd_extra", 64'(mem_addr));
      else chk("rd_addr", 64'(mem_addr), 64'(exp_rd.pop_front()));
    end
    if (driven) begin
      chk("bus_oe_excl", 64'(npu_oe), 64'd0);
      chk("we_flag", 64'(npu_we), 64'(run_len == 0));
      if (exp_bus.size() == 0) flag_fail("bus_extra", 64'(npu_bus));
      else chk("bus_word", 64'(npu_bus), 64'(exp_bus.pop_front()));
      run_len++;
    end else if (run_len != 0) begin
      if (exp_run.size() == 0) flag_fail("run_extra", 64'(run_len));
      else chk("bus_run_len", 64'(run_len), 64'(exp_run.pop_front()));
      run_len    = 0;
      wait_entry = cyc;
      if (!cur_to) armed = 1;
    end
    if (npu_oe) chk("oe_in_send", 64'(send_mode), 64'd1);
    if (res_valid && !res_ready) chk("oe_stall", 64'(npu_oe), 64'd0);
    if (res_valid && res_ready) begin
      if (exp_res.size() == 0) flag_fail("res_extra", {31'd0, res_last, res_data});
      else chk("res_word", {31'd0, res_last, res_data}, 64'(exp_res.pop_front()));
      if (res_last) last_hs = cyc;
    end
    if (done || err) begin
      chk("busy_at_end", 64'(busy), 64'd0);
      if (exp_end.size() == 0) flag_fail("end_extra", {62'd0, done, err});
      else chk("end_kind", {62'd0, done, err}, 64'(exp_end.pop_front()));
      if (done) chk("done_timing", 64'(cyc), 64'(last_hs + 1));
      if (err && cur_to) chk("timeout_cycle", 64'(cyc), 64'(wait_entry + 16));
      ended++;
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst) mon_step();
  end

  // SRAM, NPU handshake and result-consumer models.
  initial begin
    bit          rd_n, oe_n;
    logic [11:0] addr_n;
    mem_rdata = 0; npu_ready = 0; res_ready = 0; send_mode = 0;
    out_idx = 0; out_cnt = 0;
    forever begin
      @(negedge clk);
      rd_n = mem_rd_en; addr_n = mem_addr; oe_n = npu_oe;
      @(posedge clk);
      #1;
      mem_rdata = rd_n ? mem[addr_n] : rnd_word();
      if (oe_n && send_mode) begin
        out_idx++;
        if (out_idx == out_cnt) begin
          send_mode = 0;
          npu_ready = 0;
        end
      end else if (npu_ready && !send_mode && out_idx == 0) begin
        send_mode = 1;
      end
      if (armed) begin
        if (rdy_cnt >= rdy_delay) begin
          npu_ready = 1;
          armed     = 0;
        end else rdy_cnt++;
      end
      if (stall_mode) begin
        if (res_valid && !first_seen) begin
          first_seen = 1;
          stall_left = 3;
        end
        if (stall_left > 0) begin
          res_ready = 0;
          stall_left--;
        end else res_ready = 1;
      end else begin
        res_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic issue_frame(input int lyr, input int n0, input int n1, input int n2,
                             input int n3, input int base, input int dly,
                             input bit stl, input bit to);
    logic [31:0] h [6];
    int dims[$];
    int w, s, a;
    logic [31:0] wd;
    h[0] = ($urandom & ~32'd3) | 32'(lyr);
    h[1] = ($urandom & ~32'h1F) | 32'(n0);
    h[2] = ($urandom & ~32'h1F) | 32'(n1);
    h[3] = ($urandom & ~32'h1F) | 32'(n2);
    h[4] = ($urandom & ~32'h1F) | 32'(n3);
    h[5] = ($urandom & ~32'h7) | 32'($urandom_range(0, 7));
    for (int i = 0; i < 6; i++) begin
      if (h[i] == 32'hFFFF_FFFF) h[i][30] = 1'b0;
      mem[(base + i) & 4095] = h[i];
      exp_rd.push_back((base + i) & 4095);
    end
    cur_to = to; rdy_delay = dly; rdy_cnt = 0; stall_mode = stl;
    first_seen = 0; stall_left = 0; out_idx = 0; out_cnt = n3 + 1;
    if (lyr == 3) begin
      exp_end.push_back(2'b01);
    end else begin
      dims.push_back(n0 + 1);
      if (lyr >= 1) dims.push_back(n1 + 1);
      if (lyr == 2) dims.push_back(n2 + 1);
      dims.push_back(n3 + 1);
      w = 0;
      for (int i = 0; i + 1 < dims.size(); i++) w += dims[i + 1] * (dims[i] + 1);
      s = w + n0 + 1;
      exp_bus.push_back(32'd0);
      for (int i = 0; i < 6; i++) exp_bus.push_back(h[i]);
      for (int k = 0; k < s; k++) begin
        a = (base + 6 + k) & 4095;
        mem[a] = rnd_word();
        exp_rd.push_back(a);
        exp_bus.push_back(mem[a]);
      end
      exp_run.push_back(7 + s);
      if (to) begin
        exp_end.push_back(2'b01);
      end else begin
        for (int k = 0; k <= n3; k++) begin
          wd = rnd_word();
          out_words[k] = wd;
          exp_res.push_back({k == n3, wd});
        end
        exp_end.push_back(2'b10);
      end
    end
    @(posedge clk); #1;
    start = 1; base_addr = 12'(base);
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_end(input int budget, input bit start_at_end);
    int target, n;
    target = ended + 1;
    n = 0;
    while (ended < target && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (start_at_end && (done || err)) begin
        start = 1; base_addr = 12'd900;
        @(posedge clk); #1;
        start = 0;
        chk("start_at_done_dropped", 64'(busy), 64'd0);
      end
    end
    if (ended < target) flag_fail("frame_budget_expired", 64'(n));
  endtask

  task automatic flush();
    exp_rd.delete(); exp_bus.delete(); exp_run.delete();
    exp_res.delete(); exp_end.delete();
    run_len = 0; armed = 0; send_mode = 0; npu_ready = 0; out_idx = 0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_we"}, 64'(npu_we), 64'd0);
    chk({tag, "_oe"}, 64'(npu_oe), 64'd0);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_res_data"}, 64'(res_data), 64'd0);
    chk({tag, "_res_last"}, 64'(res_last), 64'd0);
    chk({tag, "_bus_z"}, 64'(npu_bus), 64'hFFFF_FFFF);
  endtask

  initial begin
    start = 0; base_addr = 0; rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 0;

    // Smallest frame: S = 5, run of 12 driven cycles.
    issue_frame(0, 1, $urandom_range(0, 31), $urandom_range(0, 31), 0, 100, 2, 0, 0);
    wait_end(500, 0);
    // Largest frame: S = 3200, gapless.
    issue_frame(2, 31, 31, 31, 31, 200, 4, 0, 0);
    wait_end(5000, 0);
    // Illegal layer count.
    issue_frame(3, 5, 5, 5, 5, 50, 0, 0, 0);
    wait_end(200, 0);
    // N3 = 4 with back-pressure after the first word; a start during busy is dropped.
    fork
      issue_frame(1, 3, 2, 0, 3, 400, 1, 1, 0);
      begin
        repeat (4) @(posedge clk);
        #2;
        start = 1; base_addr = 12'd1000;
        @(posedge clk); #2;
        start = 0;
      end
    join
    wait_end(500, 0);

    // Reset in the middle of STREAM, then a clean frame.
    issue_frame(2, 20, 20, 20, 20, 600, 0, 0, 0);
    repeat (30) @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk_idle_outputs("abort");
    flush();
    @(posedge clk); #1;
    rst = 0;
    issue_frame(1, 7, 9, 0, 5, 700, 3, 0, 0);
    wait_end(800, 0);

    // Address wrap at the top of SRAM, plus a start in the done cycle.
    issue_frame(1, 10, 12, 0, 6, 4090, 5, 0, 0);
    wait_end(1000, 1);

    for (int i = 0; i < 6; i++) begin
      issue_frame($urandom_range(0, 2), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 4095),
                  $urandom_range(0, 10), $urandom_range(0, 1), 0);
      wait_end(5000, 0);
    end

`ifdef NPU_HOST_TIMEOUT_EN
    issue_frame(0, 2, 0, 0, 1, 1500, 0, 0, 1);
    wait_end(500, 0);
`endif

    repeat (5) @(posedge clk);
    chk("left_rd", 64'(exp_rd.size()), 64'd0);
    chk("left_bus", 64'(exp_bus.size()), 64'd0);
    chk("left_res", 64'(exp_res.size()), 64'd0);
    chk("left_end", 64'(exp_end.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
